// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the branch/trap resolution stage.
//   - cmp_op encodings for the MIPS conditional branches and traps
//     (codes 10-15 are NOPs)
//   - is_branch_op / is_trap_op helpers that classify a cmp_op value
//   - state_t: resolution-stage state, IDLE or waiting on a trap ack
package cpu_pkg;

  localparam logic [3:0] BEQ  = 4'd0;
  localparam logic [3:0] BNE  = 4'd1;
  localparam logic [3:0] BGEZ = 4'd2;
  localparam logic [3:0] BGTZ = 4'd3;
  localparam logic [3:0] BLEZ = 4'd4;
  localparam logic [3:0] BLTZ = 4'd5;
  localparam logic [3:0] TEQ  = 4'd6;
  localparam logic [3:0] TNE  = 4'd7;
  localparam logic [3:0] TGE  = 4'd8;
  localparam logic [3:0] TLT  = 4'd9;

  typedef enum logic {
    IDLE      = 1'b0,
    TRAP_PEND = 1'b1
  } state_t;

  function automatic logic is_branch_op(input logic [3:0] op);
    return (op <= BLTZ);
  endfunction

  function automatic logic is_trap_op(input logic [3:0] op);
    return (op >= TEQ) && (op <= TLT);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational condition evaluator for branches and traps.
// Ports:
//   op    - cmp_op encoding (cpu_pkg)
//   a, b  - rs / rt operands, DATA_W bits
//   cond  - condition result (0 for NOP codes)
//   is_br - op is a conditional branch
//   is_tr - op is a conditional trap
module cond_eval
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              cond,
  output logic              is_br,
  output logic              is_tr
);

  logic a_neg;
  logic a_zero;

  // Compares against zero are signed, so they reduce to the sign bit
  // and a zero test of rs; rt is ignored for those ops.
  assign a_neg  = a[DATA_W-1];
  assign a_zero = (a == '0);

  assign is_br = is_branch_op(op);
  assign is_tr = is_trap_op(op);

  always_comb begin
    cond = 1'b0;
    case (op)
      BEQ:     cond = (a == b);
      BNE:     cond = (a != b);
      BGEZ:    cond = !a_neg;
      BGTZ:    cond = !a_neg && !a_zero;
      BLEZ:    cond = a_neg || a_zero;
      BLTZ:    cond = a_neg;
      TEQ:     cond = (a == b);
      TNE:     cond = (a != b);
      TGE:     cond = ($signed(a) >= $signed(b));
      TLT:     cond = ($signed(a) <  $signed(b));
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_trap_unit.sv
// branch_trap_unit: registered branch/trap resolution stage (1-cycle latency).
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   valid_in / ready_out  - op handshake; ready_out is combinational
//   cmp_op, data_in1/2    - operation and rs/rt operands
//   pc_in, target_in      - instruction PC and taken target
//   pred_taken, stall     - front-end prediction, downstream stall
//   valid_out             - pulse one cycle after each accepted op
//   is_taken              - condition of the last accepted branch
//   redirect, redirect_pc - mispredict pulse and corrected next PC
//   trap_req, trap_pc     - pending trap and its PC, held until trap_ack
//   clr_cnt               - clears both statistics counters
//   br_cnt, mis_cnt       - saturating branch / mispredict counters
module branch_trap_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int PC_W        = 32,
  parameter int FALL_OFFSET = 8,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [3:0]        cmp_op,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [PC_W-1:0]   target_in,
  input  logic              pred_taken,
  input  logic              stall,
  output logic              valid_out,
  output logic              is_taken,
  output logic              redirect,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              trap_req,
  output logic [PC_W-1:0]   trap_pc,
  input  logic              trap_ack,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  mis_cnt
);

  state_t            state_q, state_d;
  logic              valid_out_q, valid_out_d;
  logic              is_taken_q, is_taken_d;
  logic              redirect_q, redirect_d;
  logic [PC_W-1:0]   redirect_pc_q, redirect_pc_d;
  logic [PC_W-1:0]   trap_pc_q, trap_pc_d;
  logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]  mis_cnt_q, mis_cnt_d;

  logic              acc;
  logic              cond;
  logic              is_br;
  logic              is_tr;
  logic              br_inc;
  logic              mis_inc;

  cond_eval #(
    .DATA_W (DATA_W)
  ) u_cond_eval (
    .op    (cmp_op),
    .a     (data_in1),
    .b     (data_in2),
    .cond  (cond),
    .is_br (is_br),
    .is_tr (is_tr)
  );

  assign ready_out = !stall && (state_q == IDLE);
  assign acc       = valid_in && ready_out;

  always_comb begin
    state_d       = state_q;
    valid_out_d   = acc;
    is_taken_d    = is_taken_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    trap_pc_d     = trap_pc_q;
    br_inc        = 1'b0;
    mis_inc       = 1'b0;

    // acc can only be high in IDLE, so trap entry lives there; a pending
    // trap leaves on ack regardless of stall.
    case (state_q)
      IDLE: begin
        if (acc && is_tr && cond) begin
          state_d   = TRAP_PEND;
          trap_pc_d = pc_in;
        end
      end
      TRAP_PEND: begin
        if (trap_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (acc && is_br) begin
      is_taken_d = cond;
      br_inc     = 1'b1;
      if (cond != pred_taken) begin
        redirect_d    = 1'b1;
        redirect_pc_d = cond ? target_in : (pc_in + PC_W'(FALL_OFFSET));
        mis_inc       = 1'b1;
      end
    end

    // Clear beats increment; increments stop at all-ones.
    br_cnt_d = br_cnt_q;
    if (clr_cnt) begin
      br_cnt_d = '0;
    end else if (br_inc && (br_cnt_q != '1)) begin
      br_cnt_d = br_cnt_q + CNT_W'(1);
    end

    mis_cnt_d = mis_cnt_q;
    if (clr_cnt) begin
      mis_cnt_d = '0;
    end else if (mis_inc && (mis_cnt_q != '1)) begin
      mis_cnt_d = mis_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      valid_out_q   <= 1'b0;
      is_taken_q    <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      trap_pc_q     <= '0;
      br_cnt_q      <= '0;
      mis_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      valid_out_q   <= valid_out_d;
      is_taken_q    <= is_taken_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      trap_pc_q     <= trap_pc_d;
      br_cnt_q      <= br_cnt_d;
      mis_cnt_q     <= mis_cnt_d;
    end
  end

  assign valid_out   = valid_out_q;
  assign is_taken    = is_taken_q;
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign trap_req    = (state_q == TRAP_PEND);
  assign trap_pc     = trap_pc_q;
  assign br_cnt      = br_cnt_q;
  assign mis_cnt     = mis_cnt_q;

endmodule

// File: tb/tb_branch_trap_unit.sv
// Testbench for branch_trap_unit: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the stage.
module tb_branch_trap_unit;
  import cpu_pkg::*;

  localparam int DATA_W  = 32;
  localparam int PC_W    = 32;
  localparam int FALL    = 8;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst;
  logic              valid_in;
  logic              ready_out;
  logic [3:0]        cmp_op;
  logic [DATA_W-1:0] data_in1;
  logic [DATA_W-1:0] data_in2;
  logic [PC_W-1:0]   pc_in;
  logic [PC_W-1:0]   target_in;
  logic              pred_taken;
  logic              stall;
  logic              valid_out;
  logic              is_taken;
  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;
  logic              trap_req;
  logic [PC_W-1:0]   trap_pc;
  logic              trap_ack;
  logic              clr_cnt;
  logic [CNT_W-1:0]  br_cnt;
  logic [CNT_W-1:0]  mis_cnt;

  int checks = 0;
  int errors = 0;

  branch_trap_unit #(
    .DATA_W      (DATA_W),
    .PC_W        (PC_W),
    .FALL_OFFSET (FALL),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .cmp_op      (cmp_op),
    .data_in1    (data_in1),
    .data_in2    (data_in2),
    .pc_in       (pc_in),
    .target_in   (target_in),
    .pred_taken  (pred_taken),
    .stall       (stall),
    .valid_out   (valid_out),
    .is_taken    (is_taken),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .trap_req    (trap_req),
    .trap_pc     (trap_pc),
    .trap_ack    (trap_ack),
    .clr_cnt     (clr_cnt),
    .br_cnt      (br_cnt),
    .mis_cnt     (mis_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state: what every output must read after the most
  // recent rising edge.
  bit        model_ok = 1'b0;
  bit        m_pend;
  bit        m_valid;
  bit        m_taken;
  bit        m_redirect;
  bit [31:0] m_rpc;
  bit [31:0] m_tpc;
  int        m_br;
  int        m_mis;

  function automatic bit spec_cond(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (op)
      4'd0:    return sa == sb;
      4'd1:    return sa != sb;
      4'd2:    return sa >= 0;
      4'd3:    return sa > 0;
      4'd4:    return sa <= 0;
      4'd5:    return sa < 0;
      4'd6:    return sa == sb;
      4'd7:    return sa != sb;
      4'd8:    return sa >= sb;
      4'd9:    return sa < sb;
      default: return 1'b0;
    endcase
  endfunction

  // Advance the model by one clock using the inputs the DUT sees at the edge.
  always @(posedge clk) begin
    bit c;
    bit acc;
    if (rst) begin
      model_ok   = 1'b1;
      m_pend     = 1'b0;
      m_valid    = 1'b0;
      m_taken    = 1'b0;
      m_redirect = 1'b0;
      m_rpc      = '0;
      m_tpc      = '0;
      m_br       = 0;
      m_mis      = 0;
    end else if (model_ok) begin
      acc        = valid_in && !stall && !m_pend;
      c          = spec_cond(cmp_op, data_in1, data_in2);
      m_valid    = acc;
      m_redirect = 1'b0;
      if (m_pend && trap_ack) m_pend = 1'b0;
      if (clr_cnt) begin
        m_br  = 0;
        m_mis = 0;
      end
      if (acc && cmp_op <= 4'd5) begin
        m_taken = c;
        if (!clr_cnt && m_br < CNT_MAX) m_br++;
        if (c != pred_taken) begin
          m_redirect = 1'b1;
          m_rpc      = c ? target_in : pc_in + 32'd8;
          if (!clr_cnt && m_mis < CNT_MAX) m_mis++;
        end
      end else if (acc && cmp_op >= 4'd6 && cmp_op <= 4'd9 && c) begin
        m_pend = 1'b1;
        m_tpc  = pc_in;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual,
               expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (model_ok) begin
      checkOutput("m.valid_out", 32'(valid_out), 32'(m_valid));
      checkOutput("m.is_taken", 32'(is_taken), 32'(m_taken));
      checkOutput("m.redirect", 32'(redirect), 32'(m_redirect));
      checkOutput("m.redirect_pc", redirect_pc, m_rpc);
      checkOutput("m.trap_req", 32'(trap_req), 32'(m_pend));
      checkOutput("m.trap_pc", trap_pc, m_tpc);
      checkOutput("m.br_cnt", 32'(br_cnt), 32'(m_br));
      checkOutput("m.mis_cnt", 32'(mis_cnt), 32'(m_mis));
      checkOutput("m.ready_out", 32'(ready_out), 32'(!stall && !m_pend));
    end
  end

  // Drive one cycle of inputs, let the edge consume them, return at edge+1.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] pc,
                               input logic [31:0] tgt, input logic pred,
                               input logic vld, input logic stl,
                               input logic ack, input logic clr);
    cmp_op     = op;
    data_in1   = a;
    data_in2   = b;
    pc_in      = pc;
    target_in  = tgt;
    pred_taken = pred;
    valid_in   = vld;
    stall      = stl;
    trap_ack   = ack;
    clr_cnt    = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(4'd15, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    rst = 1'b1;
    cmp_op = 4'd15; data_in1 = '0; data_in2 = '0; pc_in = '0; target_in = '0;
    pred_taken = 1'b0; valid_in = 1'b0; stall = 1'b0; trap_ack = 1'b0;
    clr_cnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.valid_out", 32'(valid_out), 32'h0);
    checkOutput("rst.trap_req", 32'(trap_req), 32'h0);
    checkOutput("rst.br_cnt", 32'(br_cnt), 32'h0);
    checkOutput("rst.ready_out", 32'(ready_out), 32'h1);
    rst = 1'b0;

    // Correctly predicted taken BEQ.
    applyStimulus(BEQ, 32'h5, 32'h5, 32'h100, 32'h200, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("beq.valid_out", 32'(valid_out), 32'h1);
    checkOutput("beq.is_taken", 32'(is_taken), 32'h1);
    checkOutput("beq.redirect", 32'(redirect), 32'h0);
    checkOutput("beq.br_cnt", 32'(br_cnt), 32'h1);
    checkOutput("beq.mis_cnt", 32'(mis_cnt), 32'h0);

    // Signed compares against zero with the most negative operand.
    applyStimulus(BGEZ, 32'h8000_0000, 32'h0, 32'h100, 32'h200, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("bgez.is_taken", 32'(is_taken), 32'h0);
    checkOutput("bgez.redirect", 32'(redirect), 32'h1);
    checkOutput("bgez.redirect_pc", redirect_pc, 32'h108);
    checkOutput("bgez.mis_cnt", 32'(mis_cnt), 32'h1);
    applyStimulus(BLTZ, 32'h8000_0000, 32'h0, 32'h100, 32'h200, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("bltz.is_taken", 32'(is_taken), 32'h1);
    checkOutput("bltz.redirect", 32'(redirect), 32'h0);
    checkOutput("bltz.br_cnt", 32'(br_cnt), 32'h3);

    // Clear, then saturate both counters with mispredicting branches.
    applyStimulus(4'd15, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("clr.br_cnt", 32'(br_cnt), 32'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(BEQ, 32'h1, 32'h2, 32'h500, 32'h600, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("sat.br_cnt", 32'(br_cnt), 32'h3);
    checkOutput("sat.mis_cnt", 32'(mis_cnt), 32'h3);
    checkOutput("sat.redirect_pc", redirect_pc, 32'h508);
    applyStimulus(BEQ, 32'h1, 32'h2, 32'h500, 32'h600, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("clrinc.br_cnt", 32'(br_cnt), 32'h0);
    checkOutput("clrinc.mis_cnt", 32'(mis_cnt), 32'h0);

    // Trap handshake: ops are refused while the trap is pending.
    applyStimulus(TEQ, 32'h7, 32'h7, 32'h300, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("teq.trap_req", 32'(trap_req), 32'h1);
    checkOutput("teq.trap_pc", trap_pc, 32'h300);
    checkOutput("teq.redirect", 32'(redirect), 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(BNE, 32'h1, 32'h2, 32'h310, 32'h400, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("pend.ready_out", 32'(ready_out), 32'h0);
      checkOutput("pend.valid_out", 32'(valid_out), 32'h0);
      checkOutput("pend.trap_req", 32'(trap_req), 32'h1);
    end
    checkOutput("pend.br_cnt", 32'(br_cnt), 32'h0);
    applyStimulus(4'd15, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("ack.trap_req", 32'(trap_req), 32'h0);
    checkOutput("ack.ready_out", 32'(ready_out), 32'h1);

    // Stall holds the op off; release accepts it exactly once.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(BEQ, 32'h9, 32'h9, 32'h700, 32'h800, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("stall.ready_out", 32'(ready_out), 32'h0);
      checkOutput("stall.valid_out", 32'(valid_out), 32'h0);
      checkOutput("stall.br_cnt", 32'(br_cnt), 32'h0);
    end
    applyStimulus(BEQ, 32'h9, 32'h9, 32'h700, 32'h800, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("release.valid_out", 32'(valid_out), 32'h1);
    checkOutput("release.br_cnt", 32'(br_cnt), 32'h1);
    idleCycle();
    checkOutput("release.once", 32'(valid_out), 32'h0);

    // Reset while a trap is pending.
    applyStimulus(TNE, 32'h1, 32'h2, 32'h400, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("tne.trap_req", 32'(trap_req), 32'h1);
    rst = 1'b1;
    idleCycle();
    checkOutput("rstpend.trap_req", 32'(trap_req), 32'h0);
    checkOutput("rstpend.trap_pc", trap_pc, 32'h0);
    checkOutput("rstpend.is_taken", 32'(is_taken), 32'h0);
    checkOutput("rstpend.redirect_pc", redirect_pc, 32'h0);
    checkOutput("rstpend.br_cnt", 32'(br_cnt), 32'h0);
    rst = 1'b0;
    idleCycle();
    checkOutput("rstpend.ready_out", 32'(ready_out), 32'h1);

    // Randomized traffic; the model comparison runs on every cycle.
    for (int i = 0; i < 3000; i++) begin
      a = pick_operand();
      b = ($urandom_range(0, 1) == 0) ? a : pick_operand();
      rst = ($urandom_range(0, 199) == 0);
      applyStimulus(4'($urandom_range(0, 15)), a, b, $urandom, $urandom,
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 19) == 0));
    end
    rst = 1'b0;
    idleCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
